// File: rtl/poly_go_feeder.sv
// poly_go_feeder: loads A, B, C, X onto the evaluator Go/DataIn handshake.
// Define POLY_GO_FEEDER_TIMEOUT_EN to add the WAIT_RES watchdog and error flag.
module poly_go_feeder #(
    parameter int GO_HIGH_CYCLES = 2,
    parameter int GO_LOW_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] coef_a,
    input  logic [7:0] coef_b,
    input  logic [7:0] coef_c,
    input  logic [7:0] coef_x,
    input  logic       result_valid,
    input  logic [7:0] data_result,
    output logic [7:0] data_out,
    output logic       go,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       error
);

    localparam int CNT_MAX = (GO_HIGH_CYCLES > GO_LOW_CYCLES) ? GO_HIGH_CYCLES : GO_LOW_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HI_LAST = CNT_W'(GO_HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] LO_LAST = CNT_W'(GO_LOW_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, GO_HI, GO_LO, WAIT_RES, DONE
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [7:0]       op_a, op_b, op_c, op_x;
    logic [7:0]       op_sel;
    logic             timed_out;

    logic [7:0] data_nx, result_nx;
    logic       go_nx, busy_nx, done_nx, error_nx;

`ifdef POLY_GO_FEEDER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            to_cnt <= '0;
        else if (state == WAIT_RES && state_nx == WAIT_RES)
            to_cnt <= to_cnt + 1'b1;
        else
            to_cnt <= '0;
    end

    assign timed_out = (to_cnt == TO_LAST);
`else
    assign timed_out = 1'b0;
`endif

    always_comb begin
        op_sel = op_a;
        unique case (idx)
            2'd0: op_sel = op_a;
            2'd1: op_sel = op_b;
            2'd2: op_sel = op_c;
            2'd3: op_sel = op_x;
            default: op_sel = op_a;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            op_a  <= '0;
            op_b  <= '0;
            op_c  <= '0;
            op_x  <= '0;
        end else begin
            state <= state_nx;
            if ((state == GO_HI || state == GO_LO) && state_nx == state)
                cnt <= cnt + 1'b1;
            else
                cnt <= '0;
            if (state == IDLE && start) begin
                idx  <= '0;
                op_a <= coef_a;
                op_b <= coef_b;
                op_c <= coef_c;
                op_x <= coef_x;
            end else if (state == GO_LO && state_nx == SETUP) begin
                idx <= idx + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     if (start) state_nx = SETUP;
            SETUP:    state_nx = GO_HI;
            GO_HI:    if (cnt == HI_LAST) state_nx = GO_LO;
            GO_LO:    if (cnt == LO_LAST) state_nx = (idx == 2'd3) ? WAIT_RES : SETUP;
            WAIT_RES: if (result_valid || timed_out) state_nx = DONE;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Outputs trail the state by one edge so data_out settles a cycle before go rises.
    always_comb begin
        data_nx   = (state == SETUP) ? op_sel : data_out;
        go_nx     = (state == GO_HI);
        busy_nx   = (state_nx != IDLE) && (state_nx != DONE);
        done_nx   = (state_nx == DONE);
        result_nx = result;
        if (state == WAIT_RES && result_valid)
            result_nx = data_result;
`ifdef POLY_GO_FEEDER_TIMEOUT_EN
        error_nx = (state == WAIT_RES) && !result_valid && timed_out;
`else
        error_nx = (TIMEOUT_CYCLES < 0);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
            go       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            error    <= 1'b0;
        end else begin
            data_out <= data_nx;
            go       <= go_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            result   <= result_nx;
            error    <= error_nx;
        end
    end

endmodule
